// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save accumulation front end.
//   DATA_W  : operand / accumulator width (fixed at the CSA width)
//   state_e : sequencer states for csa_accum_ctrl
package csa_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC     = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage : csa_pkg

// File: rtl/csa_accum_ctrl_csa.sv
// 64-bit 3:2 carry-save adder (combinational).
//   x, y, z : three addends
//   u       : bitwise sum  (x ^ y ^ z)
//   v       : carry vector, already shifted left one place (v[0] = 0);
//             the carry out of bit 63 is dropped, so u + v == x + y + z mod 2**64
module csa_accum_ctrl_csa
    import csa_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [DATA_W-1:0] z,
    output logic [DATA_W-1:0] u,
    output logic [DATA_W-1:0] v
);

    logic [DATA_W-1:0] maj;

    assign maj = (x & y) | (x & z) | (y & z);
    assign u   = x ^ y ^ z;
    assign v   = {maj[DATA_W-2:0], 1'b0};

endmodule : csa_accum_ctrl_csa

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator sequencer. Streams operands through one shared
// carry-save adder, keeping the running total as a (sum, carry) pair, then
// resolves it with a single carry-propagate add and holds the result until
// the consumer takes it.
//   clk, rst            : clock, synchronous active-high reset
//   start, count        : job request and operand count (sampled in IDLE)
//   in_data/valid/ready : operand stream
//   result/out_valid/out_ready : result handshake (result held while valid)
//   busy                : high in every state except IDLE
module csa_accum_ctrl
    import csa_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    state_e            state_q,     state_d;
    logic [DATA_W-1:0] sum_q,       sum_d;
    logic [DATA_W-1:0] carry_q,     carry_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [DATA_W-1:0] result_q,    result_d;

    logic [DATA_W-1:0] csa_u;
    logic [DATA_W-1:0] csa_v;

    csa_accum_ctrl_csa u_csa (
        .x (sum_q),
        .y (carry_q),
        .z (in_data),
        .u (csa_u),
        .v (csa_v)
    );

    always_comb begin
        // NOTE: every signal gets a hold value first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        remaining_d = remaining_q;
        result_d    = result_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sum_d       = '0;
                    carry_d     = '0;
                    remaining_d = count;
                    state_d     = (count != '0) ? ACC : RESOLVE;
                end
            end
            ACC: begin
                // in_ready is 1 throughout ACC, so in_valid alone is an accept.
                if (in_valid) begin
                    sum_d       = csa_u;
                    carry_d     = csa_v;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                result_d = sum_q + carry_q;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset along with the state, so a
        // job aborted by reset leaves no partial sum or stale result behind.
        if (rst) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            carry_q     <= '0;
            remaining_q <= '0;
            result_q    <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            remaining_q <= remaining_d;
            result_q    <= result_d;
        end
    end

    // Moore-decoded outputs.
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;

endmodule : csa_accum_ctrl
